dm_access_unit: RTL and testbench
=================================

# dm_access_unit

Sub-word access controller between the EX/MEM pipeline register and the word-only data memory (`add`, `data`, `memW`, `memR`, `pc`, `WB`). Stores are aligned and byte/half stores are turned into a two-cycle read-modify-write. Loads are extended into a registered result. Misaligned accesses are flagged without touching memory.

## Interface
- `ADDR_W`, 32, byte address width
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; low forces every register to its reset value immediately.
- `req_valid` input 1: access request present this cycle.
- `op` input 3: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- `addr` input 32: byte address.
- `wdata` input 32: store data, right-aligned.
- `req_pc` input 32: PC of the requesting instruction.
- `stall` output 1: hold the request and freeze upstream stages.
- `load_data` output 32: extended load result (registered).
- `load_valid` output 1: one-cycle pulse; `load_data` is valid.
- `exc` output 1: one-cycle pulse on a misaligned access (registered).
- `exc_addr` output 32: faulting address (registered).
- `dm_add` output 32: word address to memory, `{addr[31:2],2'b00}`.
- `dm_data` output 32: write word to memory.
- `dm_memW` output 1: memory write enable.
- `dm_memR` output 1: memory read enable.
- `dm_pc` output 32: PC forwarded to memory for its write log.
- `dm_rdata` input 32: combinational read word from memory.

## Operation
- The FSM has two states, IDLE and WRITE. Reset state is IDLE.
- Alignment rules:
  - LW and SW require `addr[1:0]==0`.
  - LH, LHU and SH require `addr[0]==0`.
  - Byte ops are always aligned.
- IDLE with `req_valid`, misaligned request:
  - No memory access: `dm_memW=0`, `dm_memR=0`.
  - Next edge: `exc=1` and `exc_addr=addr`.
- IDLE, aligned SW:
  - Drive `dm_memW=1`, `dm_data=wdata`, `dm_pc=req_pc` this cycle.
  - `stall=0`; state stays IDLE.
- IDLE, aligned SH or SB:
  - Drive `dm_memR=1` with `stall=1`.
  - Next edge: latch `merged` (= `dm_rdata` with the target lane replaced), latch the word address and `req_pc`, then go to WRITE.
  - SB lane k = `addr[1:0]`: bits [8k+7:8k] become `wdata[7:0]`.
  - SH: `addr[1]=0` replaces [15:0], `addr[1]=1` replaces [31:16], with `wdata[15:0]`.
  - Little-endian lane numbering throughout.
- WRITE:
  - Drive `dm_memW=1`, `dm_data=merged`, `dm_add` and `dm_pc` from the latched values.
  - `stall=0`. `req_valid` is ignored, because it is the same held request.
  - Next edge: go to IDLE.
- IDLE, aligned load:
  - Drive `dm_memR=1` with `stall=0`.
  - Next edge: `load_data` = extension of the selected lane, `load_valid=1`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Idle outputs: when no request is accepted, `dm_memW=0` and `dm_memR=0`. `dm_add`, `dm_data` and `dm_pc` are don't-care but are driven from the request inputs.
- Reset:
  - `reset` low forces `dm_memW=0` and `dm_memR=0` combinationally.
  - All registers clear: `load_data=0`, `load_valid=0`, `exc=0`, `exc_addr=0`, `merged=0`, state IDLE, `stall=0`.

## Timing
- SW takes 1 cycle, with no stall.
- SB/SH take 2 cycles:
  - Cycle 1: read, `stall=1`.
  - Cycle 2: write, `stall=0`.
  - The pipeline advances at the end of cycle 2.
- Loads: `load_valid`/`load_data` appear one cycle after the accept cycle.
- Back-to-back:
  - A load or store accepted in the cycle after WRITE sees the merged word, because the memory was written at the WRITE edge.
  - Two consecutive SBs to the same word both survive.
- Reset low during WRITE: the write is suppressed. The merged data is lost and the state is IDLE on release.
- Misaligned request: `exc` pulses for exactly one cycle per accepted request, with `stall=0`.

## Test plan
- SB sequence on memory initialised to 0: SB 0x11 @0x4, SB 0x22 @0x5, SB 0x33 @0x6, SB 0x44 @0x7, then LW @0x4 -> `load_data=0x44332211`; `stall` high for exactly one cycle per SB.
- Byte loads: SW 0x80FF7F01 @0x8, then LB @0xB -> `0xFFFFFF80`; LBU @0xB -> `0x00000080`; LH @0xA -> `0xFFFF80FF`; LHU @0x8 -> `0x00007F01`.
- SH and back-to-back load: SH 0xBEEF @0x12 over word 0x12345678 -> memory word `0xBEEF5678`; an immediately following LW @0x10 returns `0xBEEF5678`.
- Misaligned requests: LW @0x2, SH @0x5, SW @0x1 -> one `exc` pulse each with `exc_addr` 0x2, 0x5, 0x1; no `dm_memW` or `dm_memR`; memory unchanged.
- Reset mid-RMW: SB 0xAA @0x20 with `reset` driven low in the WRITE cycle -> no `dm_memW` pulse, word 0x20 unchanged, all outputs at reset values, next request accepted in IDLE.

Source files
------------

// File: rtl/dm_access_unit.sv
// Sub-word access controller in front of a word-only data memory.
// SW goes straight through, SH/SB become read-modify-write, loads are extended and registered.
module dm_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       req_pc,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              exc,
  output logic [ADDR_W-1:0] exc_addr,
  output logic [ADDR_W-1:0] dm_add,
  output logic [31:0]       dm_data,
  output logic              dm_memW,
  output logic              dm_memR,
  output logic [31:0]       dm_pc,
  input  logic [31:0]       dm_rdata
);

  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;
  localparam logic IDLE  = 1'b0;
  localparam logic WRITE = 1'b1;

  logic              state;
  logic [31:0]       merged;
  logic [ADDR_W-1:0] wr_add;
  logic [31:0]       wr_pc;

  logic              mis, is_load, is_rmw, acc;
  logic [ADDR_W-1:0] word_add;
  logic [31:0]       merge_w, ext;
  logic [7:0]        lb;
  logic [15:0]       lh;

  always_comb begin
    mis = 1'b0;
    case (op)
      OP_LW, OP_SW:         mis = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = addr[0];
      default:              mis = 1'b0;
    endcase
  end

  assign is_load  = (op <= OP_LBU);
  assign is_rmw   = (op == OP_SH) || (op == OP_SB);
  assign acc      = (state == IDLE) && req_valid && !mis;
  assign word_add = {addr[ADDR_W-1:2], 2'b00};

  // Lane replacement for the RMW write word, little-endian lanes.
  always_comb begin
    merge_w = dm_rdata;
    if (op == OP_SB)
      merge_w[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    else
      merge_w[{addr[1], 4'b0000} +: 16] = wdata[15:0];
  end

  always_comb begin
    lb  = dm_rdata[{addr[1:0], 3'b000} +: 8];
    lh  = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    ext = dm_rdata;
    case (op)
      OP_LH:   ext = {{16{lh[15]}}, lh};
      OP_LHU:  ext = {16'h0000, lh};
      OP_LB:   ext = {{24{lb[7]}}, lb};
      OP_LBU:  ext = {24'h000000, lb};
      default: ext = dm_rdata;
    endcase
  end

  assign dm_add  = (state == WRITE) ? wr_add : word_add;
  assign dm_data = (state == WRITE) ? merged : wdata;
  assign dm_pc   = (state == WRITE) ? wr_pc  : req_pc;
  // Memory strobes are gated by reset so an in-flight write is dropped at once.
  assign dm_memW = reset && ((state == WRITE) || (acc && op == OP_SW));
  assign dm_memR = reset && acc && (is_load || is_rmw);
  assign stall   = reset && acc && is_rmw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      merged     <= '0;
      wr_add     <= '0;
      wr_pc      <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      exc        <= 1'b0;
      exc_addr   <= '0;
    end else begin
      load_valid <= acc && is_load;
      exc        <= (state == IDLE) && req_valid && mis;
      if (acc && is_load)
        load_data <= ext;
      if ((state == IDLE) && req_valid && mis)
        exc_addr <= addr;
      if (state == WRITE) begin
        state <= IDLE;
      end else if (acc && is_rmw) begin
        merged <= merge_w;
        wr_add <= word_add;
        wr_pc  <= req_pc;
        state  <= WRITE;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a small word memory model.
module tb_dm_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  op;
  logic [31:0] addr, wdata, req_pc;
  logic        stall, load_valid, exc, dm_memW, dm_memR;
  logic [31:0] load_data, exc_addr, dm_add, dm_data, dm_pc, dm_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int memw_cnt = 0, memr_cnt = 0, exc_cnt = 0;

  logic [31:0] mem [0:63];
  logic [31:0] last_wpc;

  dm_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .op(op), .addr(addr),
    .wdata(wdata), .req_pc(req_pc), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .exc(exc), .exc_addr(exc_addr), .dm_add(dm_add),
    .dm_data(dm_data), .dm_memW(dm_memW), .dm_memR(dm_memR), .dm_pc(dm_pc),
    .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_add[7:2]];

  always @(posedge clk) begin
    if (dm_memW) begin
      mem[dm_add[7:2]] <= dm_data;
      last_wpc <= dm_pc;
      memw_cnt++;
    end
    if (dm_memR) memr_cnt++;
  end

  always @(negedge clk) if (exc) exc_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue at a negedge, hold while stalled, return at the negedge after the final edge.
  task automatic do_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                        output int nstall);
    req_valid = 1'b1; op = o; addr = a; wdata = w; req_pc = 32'h1000 + a;
    nstall = 0;
    #1;
    while (stall && nstall < 4) begin
      nstall++;
      @(negedge clk); #1;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, w0, r0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h12345678;
    mem[8]  = 32'h01020304;
    last_wpc = 32'h0;
    reset = 1'b0; req_valid = 1'b1; op = 3'd5; addr = 32'h4; wdata = 32'hDEAD; req_pc = 32'h0;
    #12;
    chk("rst_memW", {31'b0, dm_memW}, 32'h0);
    chk("rst_memR", {31'b0, dm_memR}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_load_valid", {31'b0, load_valid}, 32'h0);
    chk("rst_exc", {31'b0, exc}, 32'h0);
    chk("rst_exc_addr", exc_addr, 32'h0);
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // byte stores assemble a word
    do_req(3'd7, 32'h4, 32'h11, ns); chk("sb0_stall", ns, 1);
    do_req(3'd7, 32'h5, 32'h22, ns); chk("sb1_stall", ns, 1);
    do_req(3'd7, 32'h6, 32'h33, ns); chk("sb2_stall", ns, 1);
    do_req(3'd7, 32'h7, 32'h44, ns); chk("sb3_stall", ns, 1);
    do_req(3'd0, 32'h4, 32'h0, ns);
    chk("lw4_stall", ns, 0);
    chk("lw4_valid", {31'b0, load_valid}, 32'h1);
    chk("lw4_data", load_data, 32'h44332211);

    // extension of byte/half loads
    do_req(3'd5, 32'h8, 32'h80FF7F01, ns); chk("sw8_stall", ns, 0);
    do_req(3'd3, 32'hB, 32'h0, ns); chk("lb_b", load_data, 32'hFFFFFF80);
    do_req(3'd4, 32'hB, 32'h0, ns); chk("lbu_b", load_data, 32'h00000080);
    do_req(3'd1, 32'hA, 32'h0, ns); chk("lh_a", load_data, 32'hFFFF80FF);
    do_req(3'd2, 32'h8, 32'h0, ns); chk("lhu_8", load_data, 32'h00007F01);
    chk("lhu_valid", {31'b0, load_valid}, 32'h1);
    @(negedge clk);
    chk("load_valid_pulse", {31'b0, load_valid}, 32'h0);

    // SH then an immediate LW of the same word
    do_req(3'd6, 32'h12, 32'hBEEF, ns); chk("sh_stall", ns, 1);
    chk("sh_mem", mem[4], 32'hBEEF5678);
    chk("sh_pc", last_wpc, 32'h1012);
    do_req(3'd0, 32'h10, 32'h0, ns); chk("lw10_data", load_data, 32'hBEEF5678);

    // misaligned requests
    w0 = memw_cnt; r0 = memr_cnt;
    exc_cnt = 0;
    do_req(3'd0, 32'h2, 32'h0, ns);
    chk("mis_lw_exc", {31'b0, exc}, 32'h1); chk("mis_lw_addr", exc_addr, 32'h2);
    do_req(3'd6, 32'h5, 32'hFFFF, ns);
    chk("mis_sh_stall", ns, 0);
    chk("mis_sh_exc", {31'b0, exc}, 32'h1); chk("mis_sh_addr", exc_addr, 32'h5);
    do_req(3'd5, 32'h1, 32'hFFFFFFFF, ns);
    chk("mis_sw_exc", {31'b0, exc}, 32'h1); chk("mis_sw_addr", exc_addr, 32'h1);
    @(negedge clk);
    chk("mis_exc_pulses", exc_cnt, 3);
    chk("mis_no_memW", memw_cnt - w0, 0);
    chk("mis_no_memR", memr_cnt - r0, 0);
    chk("mis_mem0", mem[0], 32'h0);
    chk("mis_mem1", mem[1], 32'h44332211);

    // reset asserted during WRITE
    req_valid = 1'b1; op = 3'd7; addr = 32'h20; wdata = 32'hAA; req_pc = 32'h2020;
    #1;
    chk("rmw_stall", {31'b0, stall}, 32'h1);
    chk("rmw_memR", {31'b0, dm_memR}, 32'h1);
    @(negedge clk); #1;
    chk("rmw_write_cycle", {31'b0, dm_memW}, 32'h1);
    w0 = memw_cnt;
    reset = 1'b0;
    #1;
    chk("rmwrst_memW", {31'b0, dm_memW}, 32'h0);
    chk("rmwrst_stall", {31'b0, stall}, 32'h0);
    chk("rmwrst_load_data", load_data, 32'h0);
    chk("rmwrst_exc_addr", exc_addr, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmwrst_no_write", memw_cnt - w0, 0);
    chk("rmwrst_mem", mem[8], 32'h01020304);
    reset = 1'b1;
    @(negedge clk);
    do_req(3'd0, 32'h20, 32'h0, ns);
    chk("post_rst_stall", ns, 0);
    chk("post_rst_valid", {31'b0, load_valid}, 32'h1);
    chk("post_rst_lw", load_data, 32'h01020304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
